// File: rtl/i2c_ram_bridge.sv
// i2c_ram_bridge: turns I2C slave byte-engine transactions into single-port
// RAM accesses. The first byte of a write transaction loads the register
// pointer, and every later byte is written at the pointer. Each byte requested
// during a read transaction is fetched from the pointer. The pointer advances
// after every access and wraps modulo 2^N. It survives STOP/START and is
// cleared only by reset.
//
// Handshake: the upstream strobes (xfer_start, xfer_stop, rx_valid, tx_req)
// are one-cycle pulses with no back-pressure. A tx_req is accepted only when
// no read is in flight (busy low). The answer is a one-cycle tx_valid pulse
// exactly three cycles after the accepted tx_req, with tx_data valid in that
// cycle. Downstream RAM strobes are one-cycle pulses. The RAM returns rdata
// one cycle after re.
module i2c_ram_bridge #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         xfer_start,
  input  logic         xfer_rw,
  input  logic         xfer_stop,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_data,
  input  logic         tx_req,
  output logic [N-1:0] tx_data,
  output logic         tx_valid,
  output logic         busy,
  output logic [N-1:0] ram_addr,
  output logic [N-1:0] ram_wdata,
  output logic         ram_we,
  output logic         ram_re,
  input  logic [N-1:0] ram_rdata
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_PTR  = 3'd1;
  localparam logic [2:0] WR_DATA  = 3'd2;
  localparam logic [2:0] RD_IDLE  = 3'd3;
  localparam logic [2:0] RD_ISSUE = 3'd4;
  localparam logic [2:0] RD_WAIT  = 3'd5;
  localparam logic [2:0] RD_CAP   = 3'd6;

  localparam logic [N-1:0] PTR_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]   state;
  logic [N-1:0] ptr;

  // Transaction FSM, pointer and registered RAM/transmit outputs.
  // Priority is reset, then (repeated) START, then STOP, then byte events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      tx_valid <= 1'b0;
      if (xfer_start) begin
        // A START (or repeated START) abandons any read in flight.
        state <= xfer_rw ? RD_IDLE : GET_PTR;
        busy  <= 1'b0;
      end else if (xfer_stop && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          GET_PTR: begin
            if (rx_valid) begin
              ptr   <= rx_data;
              state <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (rx_valid) begin
              ram_we    <= 1'b1;
              ram_addr  <= ptr;
              ram_wdata <= rx_data;
              ptr       <= ptr + PTR_ONE;
            end
          end
          RD_IDLE: begin
            if (tx_req) begin
              ram_re   <= 1'b1;
              ram_addr <= ptr;
              ptr      <= ptr + PTR_ONE;
              busy     <= 1'b1;
              state    <= RD_ISSUE;
            end
          end
          RD_ISSUE: begin
            // RAM is latching the address; its data appears next cycle.
            state <= RD_WAIT;
          end
          RD_WAIT: begin
            tx_data  <= ram_rdata;
            tx_valid <= 1'b1;
            state    <= RD_CAP;
          end
          RD_CAP: begin
            busy  <= 1'b0;
            state <= RD_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_ram_bridge.sv
// tb_i2c_ram_bridge: directed scenarios followed by randomized traffic. A
// behavioural RAM sits on the downstream port. A transaction-level reference
// model predicts every output cycle by cycle.
module tb_i2c_ram_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       xfer_start = 1'b0;
  logic       xfer_rw = 1'b0;
  logic       xfer_stop = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_re;
  logic [7:0] ram_rdata = 8'h00;

  int n_chk  = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;

  logic [7:0] ram_mem [256];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got;

  i2c_ram_bridge #(.N(8)) dut (
    .clk(clk), .rst(rst),
    .xfer_start(xfer_start), .xfer_rw(xfer_rw), .xfer_stop(xfer_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM with one-cycle registered read ----------------
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
  end

  // ---------------- reference model ----------------
  // Mode of the current transaction, plus a countdown for an accepted read:
  // 3 cycles of busy, with the byte delivered in the last of them.
  localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;
  int         m_mode = M_IDLE;
  int         m_cnt  = 0;
  logic [7:0] m_ptr  = 8'h00;
  logic [7:0] m_raddr = 8'h00;
  logic [7:0] m_mem [256];
  logic       e_we = 1'b0, e_re = 1'b0, e_tv = 1'b0;
  logic [7:0] e_addr = 8'h00, e_wd = 8'h00;

  always @(posedge clk) begin
    e_we = 1'b0;
    e_re = 1'b0;
    e_tv = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_ptr = 8'h00; e_addr = 8'h00; e_wd = 8'h00;
    end else if (xfer_start) begin
      m_mode = xfer_rw ? M_RD : M_PTR;
      m_cnt  = 0;
    end else if (xfer_stop && m_mode != M_IDLE) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else if (m_cnt != 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 1) begin
        e_tv = 1'b1;
        exp_q.push_back(m_mem[m_raddr]);
      end
    end else begin
      if (m_mode == M_PTR && rx_valid) begin
        m_ptr  = rx_data;
        m_mode = M_WR;
      end else if (m_mode == M_WR && rx_valid) begin
        e_we = 1'b1; e_addr = m_ptr; e_wd = rx_data;
        m_mem[m_ptr] = rx_data;
        m_ptr = m_ptr + 8'd1;
      end else if (m_mode == M_RD && tx_req) begin
        e_re = 1'b1; e_addr = m_ptr; m_raddr = m_ptr;
        m_ptr = m_ptr + 8'd1;
        m_cnt = 3;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One compare process: every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
      chk("ram_re", {31'd0, ram_re}, {31'd0, e_re});
      chk("we_re_exclusive", {31'd0, ram_we & ram_re}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, e_tv});
      chk("ptr", {24'd0, dut.ptr}, {24'd0, m_ptr});
      if (e_we || e_re) chk("ram_addr", {24'd0, ram_addr}, {24'd0, e_addr});
      if (e_we) chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, e_wd});
      if (e_tv && exp_q.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      if (tx_valid) got_q.push_back(tx_data);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic r, input logic s, input logic rw, input logic sp,
                       input logic rv, input logic [7:0] rd, input logic tr);
    @(negedge clk);
    rst = r; xfer_start = s; xfer_rw = rw; xfer_stop = sp;
    rx_valid = rv; rx_data = rd; tx_req = tr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic start(input logic rw);  drive(0, 1, rw, 0, 0, 8'h00, 0); endtask
  task automatic stop();                 drive(0, 0, 0, 1, 0, 8'h00, 0); endtask
  task automatic rx(input logic [7:0] d); drive(0, 0, 0, 0, 1, d, 0);    endtask
  task automatic treq();                 drive(0, 0, 0, 0, 0, 8'h00, 1); endtask

  task automatic take_got(input string name, input logic [7:0] exp);
    if (got_q.size() == 0) chk({name, "_present"}, 32'd0, 32'd1);
    else begin
      got = got_q.pop_front();
      chk(name, {24'd0, got}, {24'd0, exp});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      m_mem[i]   = 8'h00;
    end
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    chk_en = 1'b1;
    drive(0, 0, 0, 0, 0, 8'h00, 0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);

    // Pointer write then three data bytes.
    start(0); rx(8'h10); rx(8'hAA); rx(8'hBB); rx(8'hCC); idle(2);
    chk("wr_model_ptr", {24'd0, m_ptr}, 32'h13);
    chk("wr_ptr", {24'd0, dut.ptr}, 32'h13);
    chk("wr_mem10", {24'd0, ram_mem[8'h10]}, 32'hAA);
    chk("wr_mem11", {24'd0, ram_mem[8'h11]}, 32'hBB);
    chk("wr_mem12", {24'd0, ram_mem[8'h12]}, 32'hCC);

    // Read back after reloading the pointer.
    stop(); start(0); rx(8'h10); start(1);
    for (int k = 0; k < 3; k++) begin treq(); idle(4); end
    take_got("rd_byte0", 8'hAA);
    take_got("rd_byte1", 8'hBB);
    take_got("rd_byte2", 8'hCC);

    // Pointer wrap.
    stop(); start(0); rx(8'hFF); rx(8'h5A); rx(8'h5B); idle(2);
    chk("wrap_memFF", {24'd0, ram_mem[8'hFF]}, 32'h5A);
    chk("wrap_mem00", {24'd0, ram_mem[8'h00]}, 32'h5B);
    chk("wrap_ptr", {24'd0, dut.ptr}, 32'h01);

    // Abort a read with STOP in T+1.
    stop(); start(1); treq(); stop(); idle(3);
    chk("abort_no_tx", got_q.size(), 32'd0);
    chk("abort_ptr", {24'd0, dut.ptr}, 32'h02);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    // Ignored events.
    start(0); treq(); stop();
    start(1); rx(8'h77); treq(); treq(); idle(4);
    chk("ign_ptr", {24'd0, dut.ptr}, 32'h03);
    chk("ign_one_tx", got_q.size(), 32'd1);
    take_got("ign_byte", 8'h00);

    // Reset in T+2 of a read.
    treq(); idle(1);
    drive(1, 0, 0, 0, 0, 8'h00, 0);
    idle(1);
    chk("rstrd_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstrd_busy", {31'd0, busy}, 32'd0);
    chk("rstrd_addr", {24'd0, ram_addr}, 32'd0);
    chk("rstrd_ptr", {24'd0, dut.ptr}, 32'd0);
    chk("rstrd_no_tx", got_q.size(), 32'd0);
    start(1); treq(); idle(4);
    take_got("rstrd_byte", 8'h5B);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 3) == 0);
    end
    idle(5);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
